// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled count, scan, PWM-breathe and blank patterns.
// Latency: tick and the updated leds appear together one edge after the step; no backpressure (enable freezes all state).
module led_pattern_gen #(
  parameter int NUM_LEDS = 8,
  parameter int DIV_W    = 26,
  parameter int PWM_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [DIV_W-1:0]    div,
  output logic [NUM_LEDS-1:0] leds,
  output logic                tick
);

  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_W-1:0] LVL_MAX = '1;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'b00,
    MODE_SCAN    = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_BLANK   = 2'b11
  } mode_e;

  logic [DIV_W-1:0]    pc_q, pc_d;
  logic [PWM_W-1:0]    pwm_q, pwm_d;
  logic [NUM_LEDS-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                dir_up_q, dir_up_d;
  logic [PWM_W-1:0]    level_q, level_d;
  logic                ramp_up_q, ramp_up_d;
  mode_e               mode_q, mode_d;
  logic                tick_q, tick_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= '0;
      pwm_q     <= '0;
      cnt_q     <= '0;
      pos_q     <= '0;
      dir_up_q  <= 1'b1;
      level_q   <= '0;
      ramp_up_q <= 1'b1;
      mode_q    <= MODE_COUNT;
      tick_q    <= 1'b0;
      leds_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      pwm_q     <= pwm_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      dir_up_q  <= dir_up_d;
      level_q   <= level_d;
      ramp_up_q <= ramp_up_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      leds_q    <= leds_d;
    end
  end

  always_comb begin
    pc_d      = pc_q;
    pwm_d     = pwm_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    dir_up_d  = dir_up_q;
    level_d   = level_q;
    ramp_up_d = ramp_up_q;
    mode_d    = mode_q;
    tick_d    = 1'b0;
    leds_d    = leds_q;

    if (enable) begin
      pwm_d = pwm_q + 1'b1;
      // >= rather than == so lowering div below pc ticks immediately
      if (pc_q >= div) begin
        tick_d = 1'b1;
        pc_d   = '0;
        if (mode_e'(mode) != mode_q) begin
          mode_d    = mode_e'(mode);
          cnt_d     = '0;
          pos_d     = '0;
          dir_up_d  = 1'b1;
          level_d   = '0;
          ramp_up_d = 1'b1;
        end else begin
          case (mode_q)
            MODE_COUNT: cnt_d = cnt_q + 1'b1;
            MODE_SCAN: begin
              if (NUM_LEDS > 1) begin
                if (dir_up_q) begin
                  if (pos_q == POS_MAX) begin
                    dir_up_d = 1'b0;
                    pos_d    = pos_q - 1'b1;
                  end else begin
                    pos_d = pos_q + 1'b1;
                  end
                end else begin
                  if (pos_q == '0) begin
                    dir_up_d = 1'b1;
                    pos_d    = pos_q + 1'b1;
                  end else begin
                    pos_d = pos_q - 1'b1;
                  end
                end
              end
            end
            MODE_BREATHE: begin
              if (ramp_up_q) begin
                if (level_q == LVL_MAX) begin
                  ramp_up_d = 1'b0;
                  level_d   = level_q - 1'b1;
                end else begin
                  level_d = level_q + 1'b1;
                end
              end else begin
                if (level_q == '0) begin
                  ramp_up_d = 1'b1;
                  level_d   = level_q + 1'b1;
                end else begin
                  level_d = level_q - 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end else begin
        pc_d = pc_q + 1'b1;
      end

      // leds follow next-state so they line up with tick at the same edge
      case (mode_d)
        MODE_COUNT:   leds_d = cnt_d;
        MODE_SCAN:    leds_d = NUM_LEDS'(1) << pos_d;
        MODE_BREATHE: leds_d = {NUM_LEDS{pwm_d < level_d}};
        default:      leds_d = '0;
      endcase
    end
  end

  assign leds = leds_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: count, scan, breathe, div change, enable freeze, blank and reset.
module tb_led_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [25:0] div;
  logic [7:0]  leds;
  logic        tick;

  int n_checks = 0;
  int n_pass   = 0;

  led_pattern_gen dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .mode   (mode),
    .div    (div),
    .leds   (leds),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] scan_exp [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    int on_cnt;
    int odd_cnt;
    int tick_cnt;

    rst    = 1'b1;
    enable = 1'b0;
    mode   = 2'b00;
    div    = 26'd3;
    cyc();
    cyc();
    chk("reset_leds", leds, 0);
    chk("reset_tick", tick, 0);

    // count mode, div=3: tick every 4 cycles, wraps after 256 ticks
    rst    = 1'b0;
    enable = 1'b1;
    for (int k = 1; k <= 1024; k++) begin
      cyc();
      chk("cnt_tick", tick, (k % 4 == 0) ? 1 : 0);
      chk("cnt_leds", leds, (k / 4) % 256);
    end
    chk("cnt_wrap", leds, 0);

    // scan from reset, div=0
    mode = 2'b01;
    div  = 26'd0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      cyc();
      chk("scan_leds", leds, scan_exp[k]);
      chk("scan_tick", tick, 1);
    end

    // breathe: 64 steps to level 64, then hold and measure duty
    mode = 2'b10;
    div  = 26'd0;
    do_reset();
    cyc();
    chk("brth_reinit", leds, 0);
    repeat (64) cyc();
    div      = 26'd1000;
    on_cnt   = 0;
    odd_cnt  = 0;
    tick_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      cyc();
      if (leds == 8'hFF) on_cnt++;
      else if (leds != 8'h00) odd_cnt++;
      if (tick) tick_cnt++;
    end
    chk("brth_on", on_cnt, 64);
    chk("brth_mixed", odd_cnt, 0);
    chk("brth_ticks", tick_cnt, 0);

    // div lowered below pc, then an enable gap
    mode = 2'b00;
    div  = 26'd20;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("div_pre", tick, 0);
    end
    div = 26'd5;
    cyc();
    chk("div_imm_tick", tick, 1);
    chk("div_imm_leds", leds, 1);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("div_gap", tick, 0);
    end
    cyc();
    chk("div_next_tick", tick, 1);
    chk("div_next_leds", leds, 2);
    enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("frz_tick", tick, 0);
      chk("frz_leds", leds, 2);
    end
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("res_gap", tick, 0);
      chk("res_leds", leds, 2);
    end
    cyc();
    chk("res_tick", tick, 1);
    chk("res_leds3", leds, 3);

    // count to 0x37, blank, back to count, async reset
    mode = 2'b00;
    div  = 26'd0;
    do_reset();
    for (int k = 1; k <= 55; k++) begin
      cyc();
      if (k == 1) chk("first_adv", leds, 1);
    end
    chk("cnt_37", leds, 8'h37);
    mode = 2'b11;
    cyc();
    chk("blank_tick", tick, 1);
    chk("blank_leds", leds, 0);
    repeat (3) cyc();
    chk("blank_hold", leds, 0);
    mode = 2'b00;
    cyc();
    chk("back_tick", tick, 1);
    chk("back_reinit", leds, 0);
    cyc();
    chk("back_first", leds, 1);
    chk("back_tick2", tick, 1);
    rst = 1'b1;
    #1;
    chk("arst_leds", leds, 0);
    chk("arst_tick", tick, 0);
    @(negedge clk);
    div = 26'd3;
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("post_rst_tick", tick, (k == 4) ? 1 : 0);
    end
    chk("post_rst_leds", leds, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
